instr_mem_responder: RTL
========================

# instr_mem_responder

Responder end of the instruction-fetch memory interface: answers the core's `instr_req`/`instr_addr` with `instr_grant`, then `instr_rvalid`/`instr_rdata`. It sits between the core's IF stage and a word-addressed instruction store, and it is the memory model the IF tracker observes in simulation and FPGA builds. Grant delay and read latency are parameterised so that tracker timing paths can be exercised. Responses are in order and bounded by an outstanding-request limit.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: instruction word width.
- `MEM_WORDS`, 1024: depth of the instruction store in words.
- `GNT_WAIT`, 0: extra cycles `instr_req` must be sampled high before grant. Range 0–15.
- `RVALID_LATENCY`, 1: cycles from the handshake edge to `instr_rvalid`. Range 1–15.
- `MAX_OUTSTANDING`, 2: granted-but-unanswered request limit. Range 1–8.
- `ERR_DATA`, 32'h0000_0000: data returned for an out-of-range fetch.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_req` in 1: fetch request; held high with a stable address until granted.
- `instr_addr` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `instr_grant` out 1: request accepted, registered.
- `instr_rvalid` out 1: response valid, one-cycle pulse per request.
- `instr_rdata` out DATA_WIDTH: instruction word, valid with `instr_rvalid`.
- `instr_err` out 1: out-of-range fetch, valid with `instr_rvalid`.
- `load_en` in 1: preload write strobe (bench/boot).
- `load_addr` in $clog2(MEM_WORDS): preload word index.
- `load_data` in DATA_WIDTH: preload word.

## Operation
- Grant FSM states:
  - IDLE: if `req` is sampled high and the queue has room, go to WAIT when GNT_WAIT>0, else to GRANT.
  - WAIT: decrement the wait counter while `req` stays high. At zero, go to GRANT. If `req` drops, return to IDLE.
  - GRANT: `instr_grant`=1 this cycle. The handshake (`req`&&`grant`) completes at the closing edge, then the FSM returns to IDLE. A waiting back-to-back `req` restarts the sequence from IDLE at that edge.
- Room means `count < MAX_OUTSTANDING`, where a response popping at the same edge counts as freed. Grant is never asserted without room.
- Handshake edge actions:
  - Store word index `addr[ADDR_WIDTH-1:2]`.
  - If the index is below MEM_WORDS, read the store. Otherwise substitute ERR_DATA and set err=1.
  - Push {data, err, countdown=RVALID_LATENCY} into the response queue.
- Each cycle, every queued entry decrements its countdown. When the head reaches zero, the outputs carry its data and err with `rvalid`=1, and the entry pops. Responses are strictly in grant order.
- Preload write:
  - `load_en` writes `load_data` at the edge.
  - A fetch of the same index at the same edge returns the old word.
  - An out-of-range `load_addr` is ignored.
- The store is not cleared by `rst`, so contents survive reset.

## Timing
- Reset values: `instr_grant`=0, `instr_rvalid`=0, `instr_rdata`=0, `instr_err`=0, FSM in IDLE, queue empty, wait counter=0.
- `rst` asserted mid-operation: outputs drop immediately, all outstanding requests are discarded, and nothing is returned for them after reset.
- GNT_WAIT=0: `req` high in cycle c gives `grant` in c+1 and the handshake at the end of c+1. The grant latency is GNT_WAIT+1 cycles after first sampling `req`.
- Handshake at the end of cycle g gives `rvalid` in cycle g+RVALID_LATENCY.
- Sustained throughput is one request per two cycles; a fixed latency guarantees at most one pop per cycle.
- A queue push and pop at the same edge are both legal. `count` stays unchanged.
- `grant` is asserted only in cycles where `req` is high.

## Structure
- `ryuki_datatypes` gains `instr_resp_entry` {data, err, countdown[3:0]} and the enum `instr_gnt_state` {IDLE, WAIT, GRANT}.
- Sub-module `instr_resp_fifo`:
  - Circular buffer of `instr_resp_entry`, depth MAX_OUTSTANDING, with wrap-around pointers.
  - Exports count, full and head.
  - Performs per-entry countdown.
- Top level holds the grant FSM, the store array and the preload port.

## Test plan
- Preload index 4 = 32'hDEAD_BEEF; GNT_WAIT=0, LAT=1; `req` with addr 0x10 in cycle 5 -> `grant` in 6, `rvalid` with DEAD_BEEF and err=0 in 7.
- GNT_WAIT=3, LAT=4; `req` from cycle 10 -> `grant` in 14, `rvalid` in 18.
- `req` addr 0x1000 with MEM_WORDS=1024 -> `rvalid` with rdata=0 and `instr_err`=1.
- MAX_OUTSTANDING=1, LAT=6, `req` held continuously -> second grant in the cycle after the first `rvalid`; responses returned in order, A then B.
- Four back-to-back fetches with `rst` pulsed between the second and third grants -> no `rvalid` for the discarded requests; post-reset fetches behave normally; preloaded data intact.
- Same-edge `load_en` to index 2 and fetch of 0x8 -> old word returned; the next fetch returns the new word.

Source files
------------

// File: rtl/instr_mem_responder_pkg.sv
// Shared types for the instruction-fetch memory responder.
//   countdown_t     : per-entry response countdown (latency up to 15)
//   instr_gnt_state : grant FSM states
package instr_mem_responder_pkg;

    localparam int unsigned CNT_W = 4;

    typedef logic [CNT_W-1:0] countdown_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StGrant
    } instr_gnt_state;

endpackage

// File: rtl/instr_resp_fifo.sv
// In-order response queue for the instruction memory responder.
// Circular buffer of {data, err, countdown} entries, DEPTH deep. Every stored
// countdown decrements each cycle (saturating at zero); the top decides when
// the head is due and pops it.
//   clk, rst       : clock, async active-high reset (pointers/count only)
//   push, push_*   : enqueue one entry
//   pop            : dequeue the head
//   count, full    : occupancy
//   head_*         : fields of the oldest entry
module instr_resp_fifo
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_BITS   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_err,
    input  countdown_t            push_countdown,
    input  logic                  pop,
    output logic [CNT_BITS-1:0]   count,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_err,
    output countdown_t            head_countdown
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
        countdown_t            countdown;
    } instr_resp_entry;

    instr_resp_entry        entries [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_BITS-1:0]    count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Payload storage needs no reset: validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].countdown != '0) begin
                entries[i].countdown <= entries[i].countdown - 1'b1;
            end
        end
        if (push) begin
            entries[wr_ptr] <= '{data: push_data, err: push_err, countdown: push_countdown};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count_q <= count_q + CNT_BITS'(push) - CNT_BITS'(pop);
        end
    end

    assign count          = count_q;
    assign full           = (count_q == CNT_BITS'(DEPTH));
    assign head_data      = entries[rd_ptr].data;
    assign head_err       = entries[rd_ptr].err;
    assign head_countdown = entries[rd_ptr].countdown;

endmodule

// File: rtl/instr_mem_responder.sv
// Responder end of the instruction-fetch interface: grants instr_req after a
// programmable wait, reads a word-addressed store at the handshake edge and
// returns the word RVALID_LATENCY cycles later, in order, with at most
// MAX_OUTSTANDING requests in flight. The store survives reset.
//   clk, rst                  : clock, async active-high reset
//   instr_req, instr_addr     : fetch request and byte address
//   instr_grant               : request accepted (registered)
//   instr_rvalid/rdata/err    : one-cycle response; err flags out-of-range
//   load_en/addr/data         : preload write port
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned GNT_WAIT        = 0,
    parameter int unsigned RVALID_LATENCY  = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req,
    input  logic [ADDR_WIDTH-1:0]        instr_addr,
    output logic                         instr_grant,
    output logic                         instr_rvalid,
    output logic [DATA_WIDTH-1:0]        instr_rdata,
    output logic                         instr_err,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]        load_data
);

    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_BITS = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    instr_gnt_state        state_q;
    countdown_t            wait_cnt_q;
    logic                  grant_q;

    logic [CNT_BITS-1:0]   count;
    logic                  full;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_err;
    countdown_t            head_countdown;

    logic                  fire;
    logic                  handshake;
    logic                  room;
    logic                  in_range;
    logic [ADDR_WIDTH-3:0] fetch_idx;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  unused_addr;

    assign fetch_idx   = instr_addr[ADDR_WIDTH-1:2];
    assign unused_addr = ^instr_addr[1:0];
    assign in_range    = {2'b00, fetch_idx} < ADDR_WIDTH'(MEM_WORDS);
    assign fetch_data  = in_range ? mem[fetch_idx[IDX_W-1:0]] : ERR_DATA;

    // Stored countdown is decremented at every edge after the push, so the head
    // is due in the cycle where it reads 1 (it would reach zero at this edge).
    assign fire      = (count != '0) && (head_countdown == countdown_t'(1));
    assign handshake = instr_req && grant_q;
    // A response popping at this edge frees its slot for the decision made here.
    assign room      = !full || fire;

    // Preload port; a same-edge fetch reads the old word via fetch_data above.
    always_ff @(posedge clk) begin
        if (load_en && (32'(load_addr) < MEM_WORDS)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            grant_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_req && room) begin
                        if (GNT_WAIT > 0) begin
                            state_q    <= StWait;
                            wait_cnt_q <= countdown_t'(GNT_WAIT - 1);
                        end else begin
                            state_q <= StGrant;
                            grant_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (!instr_req) begin
                        state_q <= StIdle;
                    end else if (wait_cnt_q == '0) begin
                        if (room) begin
                            state_q <= StGrant;
                            grant_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                StGrant: begin
                    // Handshake completes at this edge; a held req restarts from idle.
                    state_q <= StIdle;
                    grant_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    instr_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_OUTSTANDING),
        .CNT_BITS   (CNT_BITS)
    ) u_resp_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (handshake),
        .push_data      (fetch_data),
        .push_err       (!in_range),
        .push_countdown (countdown_t'(RVALID_LATENCY)),
        .pop            (fire),
        .count          (count),
        .full           (full),
        .head_data      (head_data),
        .head_err       (head_err),
        .head_countdown (head_countdown)
    );

    assign instr_grant  = grant_q;
    assign instr_rvalid = fire;
    assign instr_rdata  = fire ? head_data : '0;
    assign instr_err    = fire & head_err;

endmodule
